// File: rtl/multdiv_div_seq_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, iteration bound and an abs helper.
package multdiv_div_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Magnitude of a two's-complement value, read as unsigned.
  // INT_MIN maps to 0x80000000, which is still correct unsigned.
  function automatic logic [WIDTH-1:0] f_abs(
    input logic [WIDTH-1:0] v
  );
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multdiv_div_seq_if.sv
// Handshake/data bundle between the multdiv unit and the divider.
// master: drives ctrl_DIV/dividend/divisor; slave: drives result/exception/resultRDY.
interface multdiv_div_seq_if;
  import multdiv_div_seq_pkg::*;

  logic             ctrl_DIV;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             resultRDY;

  modport master (
    output ctrl_DIV,
    output dividend,
    output divisor,
    input  result,
    input  exception,
    input  resultRDY
  );

  modport slave (
    input  ctrl_DIV,
    input  dividend,
    input  divisor,
    output result,
    output exception,
    output resultRDY
  );

endinterface

// File: rtl/multdiv_div_seq_counter5b.sv
// 5-bit iteration counter: async clear, sync clear, count enable.
// Ports: clk_i, clr_i (async), sclr_i (sync), en_i, cnt_o.
module counter5b
  import multdiv_div_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             sclr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multdiv_div_seq.sv
// Iterative signed 32-bit restoring divider (quotient only, 32 steps).
// Ports: clock, clr (async reset), bus (slave: ctrl_DIV in; result/exception/resultRDY out).
module multdiv_div_seq
  import multdiv_div_seq_pkg::*;
(
  input  logic              clock,
  input  logic              clr,
  multdiv_div_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;

  logic             start;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] q_step;

  assign start = bus.ctrl_DIV;

  counter5b u_cnt (
    .clk_i  (clock),
    .clr_i  (clr),
    .sclr_i (start),
    .en_i   (state_q == S_RUN),
    .cnt_o  (cnt)
  );

  // Remainder stays below M <= 2^31, so the shifted A fits in WIDTH bits;
  // the extra bit of T is only the borrow.
  always_comb begin
    a_sh   = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
    q_sh   = {q_q[WIDTH-2:0], 1'b0};
    t      = {1'b0, a_sh} - {1'b0, m_q};
    a_step = t[WIDTH] ? a_sh : t[WIDTH-1:0];
    q_step = {q_sh[WIDTH-1:1], ~t[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (start) begin
      a_d     = '0;
      q_d     = f_abs(bus.dividend);
      m_d     = f_abs(bus.divisor);
      neg_d   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      dz_d    = (bus.divisor == '0);
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          a_d = a_step;
          q_d = q_step;
          if (cnt == ITER_LAST) begin
            state_d = S_DONE;
            exc_d   = dz_q;
            if (dz_q)
              res_d = '0;
            else if (neg_q)
              res_d = ~q_step + 1'b1;
            else
              res_d = q_step;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.exception = exc_q;
  assign bus.resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_multdiv_div_seq.sv
// Directed self-checking bench for multdiv_div_seq.
// Checks latency, sign handling, divide-by-zero, restart and async reset.
module tb_multdiv_div_seq;

  logic clock;
  logic clr;
  int   n_pass;
  int   n_tot;

  multdiv_div_seq_if bus ();

  multdiv_div_seq dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ctrl_DIV = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic run_div(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] res,
    output logic        exc
  );
    start_op(a, b);
    lat = 0;
    while (bus.resultRDY !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    res = bus.result;
    exc = bus.exception;
  endtask

  task automatic test_reset;
    clr          = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    n_tot++;
    if ({bus.result, bus.exception, bus.resultRDY} !== 34'd0)
      $display("FAIL reset_out: got %h want 0",
               {bus.result, bus.exception, bus.resultRDY});
    else n_pass++;
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    logic [31:0] r;
    logic e;
    run_div(32'd100, 32'd7, lat, r, e);
    n_tot++;
    if (lat !== 32) $display("FAIL basic_lat: got %0d want 32", lat);
    else n_pass++;
    n_tot++;
    if (r !== 32'd14) $display("FAIL basic_res: got %h want %h", r, 32'd14);
    else n_pass++;
    n_tot++;
    if (e !== 1'b0) $display("FAIL basic_exc: got %b want 0", e);
    else n_pass++;
    @(posedge clock);
    #1;
    n_tot++;
    if (bus.resultRDY !== 1'b0)
      $display("FAIL basic_pulse: got %b want 0", bus.resultRDY);
    else n_pass++;
    n_tot++;
    if (bus.result !== 32'd14)
      $display("FAIL basic_hold: got %h want %h", bus.result, 32'd14);
    else n_pass++;
  endtask

  task automatic test_signs;
    logic [31:0] va [4] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd3};
    logic [31:0] vb [4] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7};
    logic [31:0] ve [4] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'd0};
    int lat;
    logic [31:0] r;
    logic e;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], lat, r, e);
      n_tot++;
      if (r !== ve[i] || e !== 1'b0 || lat !== 32)
        $display("FAIL signs_%0d: got %h/%b/%0d want %h/0/32",
                 i, r, e, lat, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero;
    int lat;
    logic [31:0] r;
    logic e;
    run_div(32'd5, 32'd0, lat, r, e);
    n_tot++;
    if (lat !== 32) $display("FAIL dz_lat: got %0d want 32", lat);
    else n_pass++;
    n_tot++;
    if (r !== 32'd0 || e !== 1'b1)
      $display("FAIL dz_out: got %h/%b want 0/1", r, e);
    else n_pass++;
    @(posedge clock);
    #1;
    n_tot++;
    if (bus.exception !== 1'b1)
      $display("FAIL dz_hold: got %b want 1", bus.exception);
    else n_pass++;
    run_div(32'd9, 32'd3, lat, r, e);
    n_tot++;
    if (r !== 32'd3 || e !== 1'b0)
      $display("FAIL dz_clear: got %h/%b want 3/0", r, e);
    else n_pass++;
  endtask

  task automatic test_boundary;
    logic [31:0] va [3] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb [3] = '{32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF};
    logic [31:0] ve [3] = '{32'h80000000, 32'h80000000, 32'd1};
    int lat;
    logic [31:0] r;
    logic e;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], lat, r, e);
      n_tot++;
      if (r !== ve[i] || e !== 1'b0 || lat !== 32)
        $display("FAIL bound_%0d: got %h/%b/%0d want %h/0/32",
                 i, r, e, lat, ve[i]);
      else n_pass++;
    end
  endtask

  task automatic test_restart;
    int lat;
    logic [31:0] r;
    logic e;
    logic early;
    early = 1'b0;
    start_op(32'd100, 32'd7);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (bus.resultRDY === 1'b1) early = 1'b1;
    end
    run_div(32'd50, 32'd5, lat, r, e);
    n_tot++;
    if (early !== 1'b0) $display("FAIL restart_early: got 1 want 0");
    else n_pass++;
    n_tot++;
    if (lat !== 32 || r !== 32'd10)
      $display("FAIL restart_res: got %h/%0d want %h/32", r, lat, 32'd10);
    else n_pass++;
  endtask

  task automatic test_abort;
    int lat;
    logic [31:0] r;
    logic e;
    logic seen;
    seen = 1'b0;
    start_op(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    #3;
    clr = 1'b1;
    #1;
    n_tot++;
    if ({bus.result, bus.exception, bus.resultRDY} !== 34'd0)
      $display("FAIL abort_out: got %h want 0",
               {bus.result, bus.exception, bus.resultRDY});
    else n_pass++;
    #3;
    clr = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.resultRDY === 1'b1) seen = 1'b1;
    end
    n_tot++;
    if (seen !== 1'b0) $display("FAIL abort_rdy: got 1 want 0");
    else n_pass++;
    run_div(32'd64, 32'd8, lat, r, e);
    n_tot++;
    if (lat !== 32 || r !== 32'd8 || e !== 1'b0)
      $display("FAIL abort_next: got %h/%b/%0d want 8/0/32", r, e, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] r;
    logic e;
    logic seen;
    seen = 1'b0;
    @(negedge clock);
    bus.ctrl_DIV = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.resultRDY === 1'b1) seen = 1'b1;
    end
    bus.ctrl_DIV = 1'b0;
    n_tot++;
    if (seen !== 1'b0) $display("FAIL hold_rdy: got 1 want 0");
    else n_pass++;
    run_div(32'd21, 32'd7, lat, r, e);
    n_tot++;
    if (lat !== 32 || r !== 32'd3)
      $display("FAIL hold_next: got %h/%0d want 3/32", r, lat);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundary();
    test_restart();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
